// File: rtl/uart_fifo_ctl.sv
// Synchronous FIFO for the UART TX/RX data paths: registered or first-word-fall-through read,
// programmable almost-full/almost-empty thresholds, fill level, flush and sticky error flags.
module uart_fifo_ctl #(
  parameter int D_WIDTH   = 8,
  parameter int D_DEPTH   = 16,
  parameter int AF_THRESH = D_DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic [D_WIDTH-1:0]           wrt_data_i,
  input  logic                         wrt_ena_i,
  input  logic                         rd_ena_i,
  input  logic                         flush_i,
  input  logic                         clr_err_i,
  output logic [D_WIDTH-1:0]           rd_data_o,
  output logic                         rd_valid_o,
  output logic                         empty_o,
  output logic                         full_o,
  output logic                         almost_empty_o,
  output logic                         almost_full_o,
  output logic [$clog2(D_DEPTH):0]     level_o,
  output logic                         overflow_o,
  output logic                         underflow_o
);

  localparam int PTR_SIZE = $clog2(D_DEPTH);
  localparam logic [PTR_SIZE:0] AF_LVL = (PTR_SIZE + 1)'(AF_THRESH);
  localparam logic [PTR_SIZE:0] AE_LVL = (PTR_SIZE + 1)'(AE_THRESH);
  localparam logic [PTR_SIZE:0] PTR_ONE = (PTR_SIZE + 1)'(1);

  logic [D_WIDTH-1:0]  mem [D_DEPTH];
  logic [PTR_SIZE:0]   wr_ptr;
  logic [PTR_SIZE:0]   rd_ptr;
  logic [PTR_SIZE:0]   level;
  logic [PTR_SIZE-1:0] wr_idx;
  logic [PTR_SIZE-1:0] rd_idx;
  logic                empty;
  logic                full;
  logic                wr_acc;
  logic                rd_acc;
  logic                ovf_set;
  logic                unf_set;

  // Status is a pure function of the registered pointers; the extra MSB separates full from empty.
  assign wr_idx = wr_ptr[PTR_SIZE-1:0];
  assign rd_idx = rd_ptr[PTR_SIZE-1:0];
  assign level  = wr_ptr - rd_ptr;
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[PTR_SIZE] != rd_ptr[PTR_SIZE]) && (wr_idx == rd_idx);

  assign level_o        = level;
  assign empty_o        = empty;
  assign full_o         = full;
  assign almost_empty_o = (level <= AE_LVL);
  assign almost_full_o  = (level >= AF_LVL);

  assign wr_acc  = wrt_ena_i && !full && !flush_i;
  assign rd_acc  = rd_ena_i && !empty && !flush_i;
  assign ovf_set = wrt_ena_i && full && !flush_i;
  assign unf_set = rd_ena_i && empty && !flush_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_acc) mem[wr_idx] <= wrt_data_i;
  end

  // A set condition in the same cycle takes priority over the clear.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      if (ovf_set)        overflow_o  <= 1'b1;
      else if (clr_err_i) overflow_o  <= 1'b0;
      if (unf_set)        underflow_o <= 1'b1;
      else if (clr_err_i) underflow_o <= 1'b0;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign rd_data_o  = mem[rd_idx];
      assign rd_valid_o = !empty;
    end else begin : g_reg
      logic [D_WIDTH-1:0] rd_data_p1;
      logic               vld_p1;

      // Stage p1: head word captured on an accepted pop, valid for exactly one cycle.
      always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
          rd_data_p1 <= '0;
          vld_p1     <= 1'b0;
        end else begin
          vld_p1 <= rd_acc;
          if (rd_acc) rd_data_p1 <= mem[rd_idx];
        end
      end

      assign rd_data_o  = rd_data_p1;
      assign rd_valid_o = vld_p1;
    end
  endgenerate

endmodule

// File: tb/tb_uart_fifo_ctl.sv
// Bench for uart_fifo_ctl: a registered-read and a FWFT instance share stimulus and are
// compared against a queue-based model of the FIFO rules.
module tb_uart_fifo_ctl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] wd = '0;
  logic       we = 1'b0, re = 1'b0, fl = 1'b0, ce = 1'b0;

  logic [7:0] o0_data, o1_data;
  logic       o0_vld, o0_empty, o0_full, o0_ae, o0_af, o0_ovf, o0_unf;
  logic       o1_vld, o1_empty, o1_full, o1_ae, o1_af, o1_ovf, o1_unf;
  logic [4:0] o0_level, o1_level;

  int nchk = 0;
  int nerr = 0;

  logic [7:0] mq[$];
  logic [7:0] m_data;
  logic       m_vld, m_ovf, m_unf;

  always #5 clk = ~clk;

  uart_fifo_ctl #(.D_WIDTH(8), .D_DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(0)) dut0 (
    .clk_i(clk), .reset_n_i(rst_n), .wrt_data_i(wd), .wrt_ena_i(we), .rd_ena_i(re),
    .flush_i(fl), .clr_err_i(ce), .rd_data_o(o0_data), .rd_valid_o(o0_vld),
    .empty_o(o0_empty), .full_o(o0_full), .almost_empty_o(o0_ae), .almost_full_o(o0_af),
    .level_o(o0_level), .overflow_o(o0_ovf), .underflow_o(o0_unf));

  uart_fifo_ctl #(.D_WIDTH(8), .D_DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1)) dut1 (
    .clk_i(clk), .reset_n_i(rst_n), .wrt_data_i(wd), .wrt_ena_i(we), .rd_ena_i(re),
    .flush_i(fl), .clr_err_i(ce), .rd_data_o(o1_data), .rd_valid_o(o1_vld),
    .empty_o(o1_empty), .full_o(o1_full), .almost_empty_o(o1_ae), .almost_full_o(o1_af),
    .level_o(o1_level), .overflow_o(o1_ovf), .underflow_o(o1_unf));

  task automatic model_reset();
    mq.delete();
    m_data = 8'h00;
    m_vld  = 1'b0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endtask

  // One clock of stimulus; the model advances from the state seen before the edge.
  task automatic step(input logic w, input logic [7:0] d, input logic r,
                      input logic f, input logic c);
    int  n;
    bit  was_full, was_empty;
    we = w; wd = d; re = r; fl = f; ce = c;
    n = mq.size();
    was_full  = (n == 16);
    was_empty = (n == 0);
    if (f) begin
      mq.delete();
      m_vld = 1'b0;
      if (c) begin m_ovf = 1'b0; m_unf = 1'b0; end
    end else begin
      if (w && was_full) m_ovf = 1'b1; else if (c) m_ovf = 1'b0;
      if (r && was_empty) m_unf = 1'b1; else if (c) m_unf = 1'b0;
      if (r && !was_empty) begin m_data = mq.pop_front(); m_vld = 1'b1; end
      else m_vld = 1'b0;
      if (w && !was_full) mq.push_back(d);
    end
    @(posedge clk); #1;
    we = 1'b0; re = 1'b0; fl = 1'b0; ce = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    nchk++;
    if ({o0_level, o0_empty, o0_full, o0_ae, o0_af, o0_vld, o0_data, o0_ovf, o0_unf} !==
        {5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      nerr++;
      $display("FAIL reset_reg: got lvl=%0d e=%b f=%b ae=%b af=%b v=%b d=%h ov=%b un=%b, exp 0 1 0 1 0 0 00 0 0",
               o0_level, o0_empty, o0_full, o0_ae, o0_af, o0_vld, o0_data, o0_ovf, o0_unf);
    end
    nchk++;
    if ({o1_level, o1_empty, o1_full, o1_vld, o1_ovf, o1_unf} !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      nerr++;
      $display("FAIL reset_fwft: got lvl=%0d e=%b f=%b v=%b ov=%b un=%b, exp 0 1 0 0 0 0",
               o1_level, o1_empty, o1_full, o1_vld, o1_ovf, o1_unf);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 15; i++) begin
      step(1'b1, 8'h11 + 8'(i), 1'b0, 1'b0, 1'b0);
      nchk++;
      if ({o0_level, o0_af, o0_full, o0_ae} !==
          {5'(mq.size()), mq.size() >= 14, 1'b0, mq.size() <= 2}) begin
        nerr++;
        $display("FAIL fill_status[%0d]: got lvl=%0d af=%b f=%b ae=%b, exp lvl=%0d", i,
                 o0_level, o0_af, o0_full, o0_ae, mq.size());
      end
    end
    step(1'b1, 8'h20, 1'b0, 1'b0, 1'b0);
    nchk++;
    if ({o0_level, o0_full, o1_level, o1_full} !== {5'd16, 1'b1, 5'd16, 1'b1}) begin
      nerr++;
      $display("FAIL fill_full: got lvl=%0d f=%b fwft lvl=%0d f=%b, exp 16 1",
               o0_level, o0_full, o1_level, o1_full);
    end
  endtask

  task automatic test_overflow_drain();
    step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    nchk++;
    if ({o0_ovf, o0_level, o1_ovf} !== {1'b1, 5'd16, 1'b1}) begin
      nerr++;
      $display("FAIL overflow: got ov=%b lvl=%0d fwft ov=%b, exp 1 16 1", o0_ovf, o0_level, o1_ovf);
    end
    for (int i = 0; i < 16; i++) begin
      nchk++;
      if (o1_data !== 8'h11 + 8'(i)) begin
        nerr++;
        $display("FAIL drain_fwft_head[%0d]: got %h exp %h", i, o1_data, 8'h11 + 8'(i));
      end
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      nchk++;
      if ({o0_vld, o0_data} !== {1'b1, 8'h11 + 8'(i)} || o0_data !== m_data) begin
        nerr++;
        $display("FAIL drain_data[%0d]: got v=%b d=%h exp v=1 d=%h", i, o0_vld, o0_data, 8'h11 + 8'(i));
      end
    end
    nchk++;
    if ({o0_empty, o0_level, o1_empty, o1_vld} !== {1'b1, 5'd0, 1'b1, 1'b0}) begin
      nerr++;
      $display("FAIL drain_empty: got e=%b lvl=%0d fwft e=%b v=%b, exp 1 0 1 0",
               o0_empty, o0_level, o1_empty, o1_vld);
    end
  endtask

  task automatic test_underflow();
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    nchk++;
    if ({o0_unf, o0_vld, o0_empty} !== {1'b1, 1'b0, 1'b1}) begin
      nerr++;
      $display("FAIL underflow: got un=%b v=%b e=%b, exp 1 0 1", o0_unf, o0_vld, o0_empty);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    nchk++;
    if ({o0_unf, o1_unf} !== {m_unf, m_unf} || m_unf !== 1'b1) begin
      nerr++;
      $display("FAIL unf_set_beats_clr: got un=%b fwft un=%b, exp 1", o0_unf, o1_unf);
    end
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    nchk++;
    if ({o0_unf, o0_ovf, o1_unf, o1_ovf} !== 4'b0000) begin
      nerr++;
      $display("FAIL clr_err: got un=%b ov=%b fwft un=%b ov=%b, exp 0 0 0 0",
               o0_unf, o0_ovf, o1_unf, o1_ovf);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    for (int i = 0; i < 8; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      d = 8'($urandom);
      nchk++;
      if (o1_data !== mq[0]) begin
        nerr++;
        $display("FAIL b2b_fwft_head[%0d]: got %h exp %h", i, o1_data, mq[0]);
      end
      step(1'b1, d, 1'b1, 1'b0, 1'b0);
      nchk++;
      if ({o0_level, o1_level, o0_vld, o0_data} !== {5'd8, 5'd8, 1'b1, m_data}) begin
        nerr++;
        $display("FAIL b2b[%0d]: got lvl=%0d fwft lvl=%0d v=%b d=%h, exp lvl=8 v=1 d=%h",
                 i, o0_level, o1_level, o0_vld, o0_data, m_data);
      end
    end
  endtask

  task automatic test_fwft();
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    nchk++;
    if ({o1_vld, o1_data, o1_empty, o0_vld} !== {1'b1, 8'hA5, 1'b0, 1'b0}) begin
      nerr++;
      $display("FAIL fwft_fallthrough: got v=%b d=%h e=%b reg v=%b, exp 1 a5 0 0",
               o1_vld, o1_data, o1_empty, o0_vld);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    nchk++;
    if ({o1_empty, o1_vld, o0_vld, o0_data} !== {1'b1, 1'b0, 1'b1, 8'hA5}) begin
      nerr++;
      $display("FAIL fwft_pop: got e=%b v=%b reg v=%b reg d=%h, exp 1 0 1 a5",
               o1_empty, o1_vld, o0_vld, o0_data);
    end
  endtask

  task automatic test_flush_reset();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b1, 1'b1, 1'b0);
    nchk++;
    if ({o0_level, o0_empty, o0_ovf, o0_unf, o0_vld, o1_vld} !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      nerr++;
      $display("FAIL flush_l5: got lvl=%0d e=%b ov=%b un=%b v=%b fwft v=%b, exp 0 1 0 0 0 0",
               o0_level, o0_empty, o0_ovf, o0_unf, o0_vld, o1_vld);
    end
    for (int i = 0; i < 16; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h99, 1'b0, 1'b1, 1'b0);
    nchk++;
    if ({o0_level, o0_full, o0_ovf, o1_ovf} !== {5'd0, 1'b0, 1'b0, 1'b0}) begin
      nerr++;
      $display("FAIL flush_full: got lvl=%0d f=%b ov=%b fwft ov=%b, exp 0 0 0 0",
               o0_level, o0_full, o0_ovf, o1_ovf);
    end
    for (int i = 0; i < 3; i++) step(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h50, 1'b1, 1'b0, 1'b0);
    // Drop reset between clock edges while a write and read are pending.
    we = 1'b1; wd = 8'h66; re = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    nchk++;
    if ({o0_level, o0_empty, o0_full, o0_ae, o0_af, o0_vld, o0_data, o0_ovf, o0_unf} !==
        {5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      nerr++;
      $display("FAIL async_reset: got lvl=%0d e=%b f=%b ae=%b af=%b v=%b d=%h ov=%b un=%b",
               o0_level, o0_empty, o0_full, o0_ae, o0_af, o0_vld, o0_data, o0_ovf, o0_unf);
    end
    nchk++;
    if ({o1_level, o1_empty, o1_vld} !== {5'd0, 1'b1, 1'b0}) begin
      nerr++;
      $display("FAIL async_reset_fwft: got lvl=%0d e=%b v=%b, exp 0 1 0", o1_level, o1_empty, o1_vld);
    end
    @(posedge clk); #1;
    we = 1'b0; re = 1'b0;
    rst_n = 1'b1;
    step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    nchk++;
    if ({o0_vld, o0_data, o0_empty} !== {1'b1, 8'h3C, 1'b1}) begin
      nerr++;
      $display("FAIL post_reset: got v=%b d=%h e=%b, exp 1 3c 1", o0_vld, o0_data, o0_empty);
    end
  endtask

  task automatic test_random();
    int bias;
    int n;
    logic [7:0] h;
    for (int i = 0; i < 600; i++) begin
      bias = ((i / 60) % 2 == 0) ? 75 : 25;
      step($urandom_range(0, 99) < bias, 8'($urandom), $urandom_range(0, 99) < (100 - bias),
           $urandom_range(0, 79) == 0, $urandom_range(0, 19) == 0);
      n = mq.size();
      nchk++;
      if ({o0_level, o0_empty, o0_full, o0_ae, o0_af, o0_ovf, o0_unf, o0_vld, o0_data} !==
          {5'(n), n == 0, n == 16, n <= 2, n >= 14, m_ovf, m_unf, m_vld, m_data}) begin
        nerr++;
        $display("FAIL rand_reg[%0d]: got lvl=%0d e=%b f=%b ae=%b af=%b ov=%b un=%b v=%b d=%h, exp lvl=%0d ov=%b un=%b v=%b d=%h",
                 i, o0_level, o0_empty, o0_full, o0_ae, o0_af, o0_ovf, o0_unf, o0_vld, o0_data,
                 n, m_ovf, m_unf, m_vld, m_data);
      end
      h = (n != 0) ? mq[0] : 8'h00;
      nchk++;
      if ({o1_level, o1_ovf, o1_unf, o1_vld, (o1_vld ? o1_data : 8'h00)} !==
          {5'(n), m_ovf, m_unf, n != 0, h}) begin
        nerr++;
        $display("FAIL rand_fwft[%0d]: got lvl=%0d ov=%b un=%b v=%b d=%h, exp lvl=%0d v=%b d=%h",
                 i, o1_level, o1_ovf, o1_unf, o1_vld, o1_data, n, n != 0, h);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow_drain();
    test_underflow();
    test_back_to_back();
    test_fwft();
    test_flush_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
